msk_and_ghpc_sched: RTL and testbench
=====================================

Name: msk_and_ghpc_sched

Overview:
- Shares one 2-share GHPC masked AND gadget (1-cycle latency, 4 fresh random bits per operation) between NREQ requesters.
- Round-robin arbitration selects one requester per issue.
- Each issue draws exactly one fresh 4-bit word from the PRNG stream.
- Gadget results are collected into a 2-entry response FIFO, tagged with the requester id.
- Sits between the masked S-box/control logic and the gadget instance.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, $clog2(NREQ), width of the response id.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester operation request.
- req_ready  out  NREQ  one-hot grant/accept.
- req_a  in  2*NREQ  share pairs of operand a; requester i uses bits [2i+1:2i].
- req_b  in  2*NREQ  share pairs of operand b; same indexing as req_a.
- rnd_valid  in  1  PRNG word valid.
- rnd_ready  out  1  PRNG word accepted.
- rnd_data  in  4  fresh randomness.
- g_ina  out  2  gadget operand a shares.
- g_inb  out  2  gadget operand b shares.
- g_rnd  out  4  gadget randomness.
- g_out  in  2  gadget output shares, valid 1 cycle after issue.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_id  out  IDW  requester index of the response.
- rsp_share  out  2  output shares; rsp_share[0]^rsp_share[1] = a&b.
- busy  out  1  in-flight op, FIFO entry or buffered randomness present.

Behaviour:
- Reset (async assert, sync release):
  - rr_ptr=0, inflight=0, both FIFO counts=0.
  - req_ready=0, rsp_valid=0, g_ina/g_inb/g_rnd=0, busy=0.
  - rnd_ready=1 from the first cycle after release.
- Rnd buffer: 2 entries.
  - rnd_ready = (rnd_cnt<2); push on rnd_valid&&rnd_ready.
  - Full buffer with a pop in the same cycle: no push that cycle (rnd_ready uses the registered count).
  - Each word is popped exactly once and never reused.
- Issue condition, cycle t: any req_valid && rnd_cnt>0 && (rsp_cnt + inflight - (rsp_valid&&rsp_ready)) < 2.
- Grant: first valid index at or after rr_ptr, wrapping modulo NREQ. On issue, rr_ptr <= grant+1 (wraps NREQ-1 -> 0). No issue: rr_ptr unchanged.
- On issue:
  - req_ready[grant]=1 in cycle t; all other bits 0.
  - g_ina/g_inb = granted shares, selected by a one-hot AND-OR mux.
  - g_rnd = rnd buffer head, popped.
  - inflight<=1, id_d<=grant.
- Non-issue cycles: g_ina, g_inb and g_rnd are driven 0. Shares of different requesters are never combined.
- Cycle t+1: g_out pushed into the response FIFO with id_d.
- Latency: earliest rsp_valid is cycle t+2. Throughput is 1 op/cycle while rsp_ready=1 and randomness is available.
- Response FIFO: 2 entries, registered outputs. rsp_valid=(rsp_cnt>0). Pop on rsp_valid&&rsp_ready. Simultaneous push+pop keeps the count. Overflow is impossible by the credit rule.
- Order: responses leave in issue order.
- Reset mid-operation: the in-flight result, FIFO contents and buffered randomness are discarded. No response is emitted for an op issued in the reset cycle.
- busy = inflight | (rsp_cnt>0) | (rnd_cnt>0).

Decomposition:
- Package msk_sched_pkg:
  - RND_W=4, NSHARES=2, RSP_DEPTH=2, RND_DEPTH=2.
  - Function for clog2 id width.
- Sub-module msk_rr_arbiter: one-hot round-robin grant plus pointer register, parameterized on NREQ.
- FIFOs stay inline (2-entry, count-based).

Test Plan:
- Single op: req_valid=4'b0001, req_a=2'b10, req_b=2'b01, rnd word 4'hA.
  - Expect req_ready=4'b0001 at t and g_rnd=4'hA at t.
  - Expect rsp_valid at t+2 with rsp_id=0 and rsp_share[0]^rsp_share[1]=1.
- Round-robin: req_valid=4'b1111 held, rnd_valid and rsp_ready held high.
  - Expect grants 0,1,2,3,0 on consecutive cycles.
  - Expect rsp_id sequence 0,1,2,3,0 starting two cycles later.
- Backpressure: rsp_ready=0, all requesters valid.
  - Exactly 2 issues, then req_ready=0.
  - Raising rsp_ready for one cycle allows exactly 1 further issue.
- Randomness starvation: rnd_valid=0 with requests pending.
  - Expect no issue and g_rnd=0.
  - Feed words 4'h3, 4'hC; expect two issues using 3 then C, each word exactly once.
- Wrap and skip: rr_ptr=3 with req_valid=4'b0110.
  - Expect grant 1, then 2, then 1.
- Async reset while inflight=1 and rsp_cnt=1.
  - Expect rsp_valid=0, req_ready=0 and busy=0 immediately.
  - Expect no stale response after release.

Source files
------------

// File: rtl/msk_sched_pkg.sv
// Shared constants for the masked AND gadget scheduler: share/randomness widths
// and queue depths, plus the id-width helper used by the top and the arbiter.
package msk_sched_pkg;

  localparam int RND_W     = 4;
  localparam int NSHARES   = 2;
  localparam int RSP_DEPTH = 2;
  localparam int RND_DEPTH = 2;

  // Never narrower than one bit, so a 2-requester build still has a usable id.
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/msk_rr_arbiter.sv
// One-hot round-robin arbiter: the search starts at ptr and wraps modulo NREQ;
// ptr moves past the winner only on cycles where the grant is actually used.
module msk_rr_arbiter
  import msk_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = id_width(NREQ)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            advance,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx,
  output logic            any_req
);

  logic [IDW-1:0] ptr;
  logic           found;

  function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] p, input int j);
    int s;
    s = int'(p) + j;
    if (s >= NREQ) s = s - NREQ;
    return IDW'(s);
  endfunction

  assign any_req = |req;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int j = 0; j < NREQ; j++) begin
      if (!found && req[wrap_idx(ptr, j)]) begin
        found                  = 1'b1;
        grant[wrap_idx(ptr, j)] = 1'b1;
        grant_idx              = wrap_idx(ptr, j);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (int'(grant_idx) == NREQ - 1) ? '0 : grant_idx + IDW'(1);
    end
  end

endmodule

// File: rtl/msk_and_ghpc_sched.sv
// Time-shares one 2-share GHPC masked AND gadget between NREQ requesters, feeding
// it one fresh PRNG word per op and returning tagged results in issue order.
//
// Handshakes: every channel transfers on a cycle where valid && ready are both 1.
// req_ready is a one-hot grant that is only raised for a requester whose
// req_valid is high; rnd_ready and rsp_valid depend only on registered counts.
module msk_and_ghpc_sched
  import msk_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = id_width(NREQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NSHARES*NREQ-1:0]   req_a,
  input  logic [NSHARES*NREQ-1:0]   req_b,
  input  logic                      rnd_valid,
  output logic                      rnd_ready,
  input  logic [RND_W-1:0]          rnd_data,
  output logic [NSHARES-1:0]        g_ina,
  output logic [NSHARES-1:0]        g_inb,
  output logic [RND_W-1:0]          g_rnd,
  input  logic [NSHARES-1:0]        g_out,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [IDW-1:0]            rsp_id,
  output logic [NSHARES-1:0]        rsp_share,
  output logic                      busy
);

  // Randomness buffer (2 entries, 1-bit pointers)
  logic [RND_W-1:0] rnd_mem [RND_DEPTH];
  logic             rnd_wr, rnd_rd;
  logic [1:0]       rnd_cnt;
  logic             rnd_push, rnd_pop;

  // Response FIFO (2 entries, 1-bit pointers)
  logic [NSHARES-1:0] rsp_mem_share [RSP_DEPTH];
  logic [IDW-1:0]     rsp_mem_id    [RSP_DEPTH];
  logic               rsp_wr, rsp_rd;
  logic [1:0]         rsp_cnt;
  logic               rsp_push, rsp_pop;

  logic               inflight;
  logic [IDW-1:0]     id_d;
  logic [2:0]         rsp_used;
  logic               credit_ok;
  logic               issue;

  logic [NREQ-1:0]    grant;
  logic [IDW-1:0]     grant_idx;
  logic               any_req;

  msk_rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req_valid),
    .advance   (issue),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_req   (any_req)
  );

  assign rnd_ready = (rnd_cnt < 2'(RND_DEPTH));
  assign rnd_push  = rnd_valid && rnd_ready;
  assign rnd_pop   = issue;

  assign rsp_valid = (rsp_cnt != 2'd0);
  assign rsp_pop   = rsp_valid && rsp_ready;
  assign rsp_push  = inflight;
  assign rsp_id    = rsp_mem_id[rsp_rd];
  assign rsp_share = rsp_mem_share[rsp_rd];

  // An in-flight op already owns a FIFO slot; a same-cycle pop frees one early.
  assign rsp_used  = {1'b0, rsp_cnt} + {2'b0, inflight} - {2'b0, rsp_pop};
  assign credit_ok = (rsp_used < 3'(RSP_DEPTH));
  assign issue     = any_req && (rnd_cnt != 2'd0) && credit_ok;

  assign req_ready = issue ? grant : '0;
  assign g_rnd     = issue ? rnd_mem[rnd_rd] : '0;

  // AND-OR share mux: with no issue every select is 0, so nothing leaks out.
  always_comb begin
    g_ina = '0;
    g_inb = '0;
    for (int i = 0; i < NREQ; i++) begin
      g_ina = g_ina | ({NSHARES{issue & grant[i]}} & req_a[NSHARES*i +: NSHARES]);
      g_inb = g_inb | ({NSHARES{issue & grant[i]}} & req_b[NSHARES*i +: NSHARES]);
    end
  end

  assign busy = inflight || (rsp_cnt != 2'd0) || (rnd_cnt != 2'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rnd_wr  <= 1'b0;
      rnd_rd  <= 1'b0;
      rnd_cnt <= 2'd0;
      for (int i = 0; i < RND_DEPTH; i++) rnd_mem[i] <= '0;
    end else begin
      if (rnd_push) begin
        rnd_mem[rnd_wr] <= rnd_data;
        rnd_wr          <= ~rnd_wr;
      end
      if (rnd_pop) rnd_rd <= ~rnd_rd;
      case ({rnd_push, rnd_pop})
        2'b10:   rnd_cnt <= rnd_cnt + 2'd1;
        2'b01:   rnd_cnt <= rnd_cnt - 2'd1;
        default: rnd_cnt <= rnd_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= 1'b0;
      id_d     <= '0;
    end else begin
      inflight <= issue;
      if (issue) id_d <= grant_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_wr  <= 1'b0;
      rsp_rd  <= 1'b0;
      rsp_cnt <= 2'd0;
      for (int i = 0; i < RSP_DEPTH; i++) begin
        rsp_mem_share[i] <= '0;
        rsp_mem_id[i]    <= '0;
      end
    end else begin
      if (rsp_push) begin
        rsp_mem_share[rsp_wr] <= g_out;
        rsp_mem_id[rsp_wr]    <= id_d;
        rsp_wr                <= ~rsp_wr;
      end
      if (rsp_pop) rsp_rd <= ~rsp_rd;
      case ({rsp_push, rsp_pop})
        2'b10:   rsp_cnt <= rsp_cnt + 2'd1;
        2'b01:   rsp_cnt <= rsp_cnt - 2'd1;
        default: rsp_cnt <= rsp_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_msk_and_ghpc_sched.sv
// Bench for msk_and_ghpc_sched: a stub gadget, a queue-based reference model of
// the scheduling rules, directed scenarios and a randomized run.
module tb_msk_and_ghpc_sched;

  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int W    = IDW + 2;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [NREQ-1:0]     req_valid = '0;
  logic [NREQ-1:0]     req_ready;
  logic [2*NREQ-1:0]   req_a = '0;
  logic [2*NREQ-1:0]   req_b = '0;
  logic                rnd_valid = 1'b0;
  logic                rnd_ready;
  logic [3:0]          rnd_data = '0;
  logic [1:0]          g_ina, g_inb;
  logic [3:0]          g_rnd;
  logic [1:0]          g_out = '0;
  logic                rsp_valid;
  logic                rsp_ready = 1'b0;
  logic [IDW-1:0]      rsp_id;
  logic [1:0]          rsp_share;
  logic                busy;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  int          m_ptr = 0;
  logic [3:0]  m_rnd_q[$];
  bit          m_inflight = 1'b0;
  logic [W-1:0] m_inf_rsp = '0;
  logic [W-1:0] exp_q[$];

  int issues_seen;

  msk_and_ghpc_sched #(.NREQ(NREQ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rnd_valid (rnd_valid),
    .rnd_ready (rnd_ready),
    .rnd_data  (rnd_data),
    .g_ina     (g_ina),
    .g_inb     (g_inb),
    .g_rnd     (g_rnd),
    .g_out     (g_out),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_share (rsp_share),
    .busy      (busy)
  );

  // clock / reset
  always #5 clk = ~clk;

  // stub gadget: remasks a&b with randomness, result one cycle after issue
  function automatic logic [1:0] gadget_f(input logic [1:0] a, input logic [1:0] b,
                                          input logic [3:0] r);
    logic x, m;
    x = (a[0] ^ a[1]) & (b[0] ^ b[1]);
    m = r[0] ^ r[3];
    return {x ^ m, m};
  endfunction

  always @(posedge clk) g_out <= gadget_f(g_ina, g_inb, g_rnd);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_ptr = 0;
    m_rnd_q.delete();
    exp_q.delete();
    m_inflight = 1'b0;
  endtask

  task automatic drive_idle();
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rnd_valid = 1'b0;
    rnd_data  = '0;
    rsp_ready = 1'b0;
  endtask

  // One cycle: drive inputs, check all outputs against the model, then advance the model.
  task automatic step(input logic [NREQ-1:0] rv, input logic [2*NREQ-1:0] a,
                      input logic [2*NREQ-1:0] b, input logic rnv,
                      input logic [3:0] rd, input logic rr);
    int   g;
    bit   exp_rnd_ready, pop, iss;
    int   used;
    logic [NREQ-1:0] exp_ready;
    logic [1:0] ea, eb;
    logic [3:0] er;
    @(negedge clk);
    req_valid = rv;
    req_a     = a;
    req_b     = b;
    rnd_valid = rnv;
    rnd_data  = rd;
    rsp_ready = rr;
    #1;
    exp_rnd_ready = (m_rnd_q.size() < 2);
    pop  = (exp_q.size() > 0) && rr;
    used = exp_q.size() + int'(m_inflight) - int'(pop);
    iss  = (rv != 0) && (m_rnd_q.size() > 0) && (used < 2);
    g    = 0;
    if (iss) begin
      for (int j = NREQ - 1; j >= 0; j--)
        if (rv[(m_ptr + j) % NREQ]) g = (m_ptr + j) % NREQ;
    end
    exp_ready = iss ? NREQ'(1) << g : '0;
    ea = iss ? a[2*g +: 2] : 2'b00;
    eb = iss ? b[2*g +: 2] : 2'b00;
    er = iss ? m_rnd_q[0] : 4'h0;
    check("req_ready", 32'(req_ready), 32'(exp_ready));
    check("rnd_ready", 32'(rnd_ready), 32'(exp_rnd_ready));
    check("g_ina", 32'(g_ina), 32'(ea));
    check("g_inb", 32'(g_inb), 32'(eb));
    check("g_rnd", 32'(g_rnd), 32'(er));
    check("rsp_valid", 32'(rsp_valid), 32'(exp_q.size() > 0));
    if (exp_q.size() > 0) begin
      check("rsp_id", 32'(rsp_id), 32'(exp_q[0][W-1:2]));
      check("rsp_share", 32'(rsp_share), 32'(exp_q[0][1:0]));
    end
    check("busy", 32'(busy),
          32'(m_inflight || exp_q.size() > 0 || m_rnd_q.size() > 0));
    // posedge effects
    if (pop) void'(exp_q.pop_front());
    if (m_inflight) exp_q.push_back(m_inf_rsp);
    m_inflight = iss;
    if (iss) begin
      m_inf_rsp = {IDW'(g), gadget_f(ea, eb, er)};
      void'(m_rnd_q.pop_front());
      m_ptr = (g + 1) % NREQ;
    end
    if (rnv && exp_rnd_ready) m_rnd_q.push_back(rd);
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    drive_idle();
    rst_n = 1'b0;
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [NREQ-1:0] rv;
    // reset state
    drive_idle();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_g_ina", 32'(g_ina), 32'h0);
    check("rst_g_inb", 32'(g_inb), 32'h0);
    check("rst_g_rnd", 32'(g_rnd), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // round-robin with everything open
    step('0, '0, '0, 1'b1, 4'h5, 1'b1);
    for (int k = 0; k < 7; k++) begin
      step(4'b1111, 8'($urandom), 8'($urandom), 1'b1, 4'($urandom), 1'b1);
      check("rr_grant", 32'(req_ready), 32'(4'b0001 << (k % 4)));
      if (k >= 2) check("rr_rsp_id", 32'(rsp_id), 32'((k - 2) % 4));
    end

    // single op
    reset_pulse();
    step('0, '0, '0, 1'b1, 4'hA, 1'b1);
    step(4'b0001, 8'b0000_0010, 8'b0000_0001, 1'b0, 4'h0, 1'b1);
    check("single_ready", 32'(req_ready), 32'h1);
    check("single_g_rnd", 32'(g_rnd), 32'hA);
    step('0, '0, '0, 1'b0, 4'h0, 1'b1);
    check("single_rsp_early", 32'(rsp_valid), 32'h0);
    step('0, '0, '0, 1'b0, 4'h0, 1'b1);
    check("single_rsp_valid", 32'(rsp_valid), 32'h1);
    check("single_rsp_id", 32'(rsp_id), 32'h0);
    check("single_rsp_xor", 32'(rsp_share[0] ^ rsp_share[1]), 32'h1);

    // backpressure
    reset_pulse();
    step('0, '0, '0, 1'b1, 4'h6, 1'b0);
    issues_seen = 0;
    for (int k = 0; k < 6; k++) begin
      step(4'b1111, 8'($urandom), 8'($urandom), 1'b1, 4'($urandom), 1'b0);
      if (req_ready != 0) issues_seen++;
    end
    check("bp_issues", 32'(issues_seen), 32'd2);
    check("bp_stalled", 32'(req_ready), 32'h0);
    issues_seen = 0;
    step(4'b1111, 8'($urandom), 8'($urandom), 1'b1, 4'($urandom), 1'b1);
    if (req_ready != 0) issues_seen++;
    for (int k = 0; k < 3; k++) begin
      step(4'b1111, 8'($urandom), 8'($urandom), 1'b1, 4'($urandom), 1'b0);
      if (req_ready != 0) issues_seen++;
    end
    check("bp_one_more", 32'(issues_seen), 32'd1);

    // randomness starvation
    reset_pulse();
    for (int k = 0; k < 3; k++) begin
      step(4'b1111, 8'($urandom), 8'($urandom), 1'b0, 4'h0, 1'b1);
      check("starve_ready", 32'(req_ready), 32'h0);
      check("starve_g_rnd", 32'(g_rnd), 32'h0);
    end
    step(4'b1111, 8'($urandom), 8'($urandom), 1'b1, 4'h3, 1'b1);
    check("starve_first_none", 32'(req_ready), 32'h0);
    step(4'b1111, 8'($urandom), 8'($urandom), 1'b1, 4'hC, 1'b1);
    check("starve_rnd3", 32'(g_rnd), 32'h3);
    step(4'b1111, 8'($urandom), 8'($urandom), 1'b0, 4'h0, 1'b1);
    check("starve_rndC", 32'(g_rnd), 32'hC);
    step(4'b1111, 8'($urandom), 8'($urandom), 1'b0, 4'h0, 1'b1);
    check("starve_reuse", 32'(req_ready), 32'h0);

    // wrap and skip from pointer 3
    reset_pulse();
    step('0, '0, '0, 1'b1, 4'h1, 1'b1);
    step(4'b0001, 8'($urandom), 8'($urandom), 1'b1, 4'h2, 1'b1);
    step(4'b0010, 8'($urandom), 8'($urandom), 1'b1, 4'h4, 1'b1);
    step(4'b0100, 8'($urandom), 8'($urandom), 1'b1, 4'h8, 1'b1);
    step(4'b0110, 8'($urandom), 8'($urandom), 1'b1, 4'h9, 1'b1);
    check("wrap_g1", 32'(req_ready), 32'b0010);
    step(4'b0110, 8'($urandom), 8'($urandom), 1'b1, 4'h7, 1'b1);
    check("wrap_g2", 32'(req_ready), 32'b0100);
    step(4'b0110, 8'($urandom), 8'($urandom), 1'b1, 4'hE, 1'b1);
    check("wrap_g3", 32'(req_ready), 32'b0010);

    // async reset with one op in flight and one response queued
    reset_pulse();
    step('0, '0, '0, 1'b1, 4'h2, 1'b0);
    step('0, '0, '0, 1'b1, 4'hB, 1'b0);
    step(4'b0001, 8'($urandom), 8'($urandom), 1'b0, 4'h0, 1'b0);
    step('0, '0, '0, 1'b0, 4'h0, 1'b0);
    step(4'b0010, 8'($urandom), 8'($urandom), 1'b0, 4'h0, 1'b0);
    @(posedge clk);
    #2;
    check("pre_rst_rsp_valid", 32'(rsp_valid), 32'h1);
    check("pre_rst_busy", 32'(busy), 32'h1);
    req_valid = 4'b1111;
    rst_n = 1'b0;
    #1;
    check("arst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("arst_req_ready", 32'(req_ready), 32'h0);
    check("arst_busy", 32'(busy), 32'h0);
    model_clear();
    @(negedge clk);
    drive_idle();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step('0, '0, '0, 1'b0, 4'h0, 1'b1);
      check("post_rst_stale", 32'(rsp_valid), 32'h0);
    end

    // randomized traffic, with one mid-run async reset
    for (int k = 0; k < 400; k++) begin
      rv = 4'($urandom_range(0, 15));
      step(rv, 8'($urandom), 8'($urandom), ($urandom_range(0, 3) != 0),
           4'($urandom), ($urandom_range(0, 3) != 0));
      if (k == 200) begin
        #2;
        rst_n = 1'b0;
        #1;
        check("rand_arst_busy", 32'(busy), 32'h0);
        model_clear();
        @(negedge clk);
        drive_idle();
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    // final report
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
